lsu_mem_master: RTL and testbench

//  Load/store initiator driving the byte-masked data memory port (addr/wdata/mask/wren/rdata).

---
 rtl/lsu_mem_master_if.sv | 39 +++
 rtl/lsu_mem_master.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Load/store request, response and data-memory port bundle for lsu_mem_master.
// Signals (names as seen from the LSU):
//   i_req_valid/o_req_ready  request handshake
//   i_req_we/funct3/addr/wdata  request fields
//   o_rsp_valid/err/rdata  one-cycle response
//   o_mem_addr/wdata/mask/wren, i_mem_rdata  word-aligned memory port
// Modports: master = the LSU itself, slave = core + memory side.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 16
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [2:0]        i_req_funct3;
    logic [31:0]       i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic              o_rsp_err;
    logic [31:0]       o_rsp_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_mask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    modport master (
        input  i_req_valid, i_req_we, i_req_funct3,
        input  i_req_addr, i_req_wdata, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_funct3,
        output i_req_addr, i_req_wdata, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator: word-aligned byte-masked memory accesses,
// splitting of word-crossing accesses, byte placement and load extension.
// Ports: i_clk, i_reset (sync, active high), bus (lsu_mem_master_if.master)
//   carrying the request handshake, the response pulse and the memory port.
module lsu_mem_master #(
    parameter int ADDR_W   = 16,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    lsu_mem_master_if.master      bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t            state_q;
    logic              ready_q;
    logic              we_q;
    logic              split_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] a_q;
    logic [3:0]        hi_mask_q;
    logic [31:0]       hi_wdata_q;
    logic [31:0]       cap_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_mask_q;
    logic              mem_wren_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    // request decode
    logic        accept;
    logic        legal_f3;
    logic        range_err;
    logic        split;
    logic        req_err;
    logic [1:0]  off;
    logic [3:0]  smask;
    logic [7:0]  lanes;
    logic [63:0] wsh;

    assign accept    = bus.i_req_valid & ready_q;
    assign off       = bus.i_req_addr[1:0];
    assign legal_f3  = bus.i_req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    assign range_err = (bus.i_req_addr >> ADDR_W) != 32'd0;

    always_comb begin
        smask = 4'b1111;
        case (bus.i_req_funct3[1:0])
            2'd0:    smask = 4'b0001;
            2'd1:    smask = 4'b0011;
            default: smask = 4'b1111;
        endcase
    end

    // lanes[3:0] is the first word, lanes[7:4] the spill into the next word
    assign lanes   = {4'b0000, smask} << off;
    assign split   = |lanes[7:4];
    assign req_err = !legal_f3 | range_err | (split & !SPLIT_EN);
    assign wsh     = {32'd0, bus.i_req_wdata} << {off, 3'b000};

    // load capture
    logic [31:0] lane_bits;
    logic [31:0] rd_m;
    logic [5:0]  up_sh;
    logic [31:0] cap_d;

    assign lane_bits = {{8{mem_mask_q[3]}}, {8{mem_mask_q[2]}},
                        {8{mem_mask_q[1]}}, {8{mem_mask_q[0]}}};
    assign rd_m      = bus.i_mem_rdata & lane_bits;
    assign up_sh     = 6'd32 - {1'b0, off_q, 3'b000};

    always_comb begin
        cap_d = cap_q;
        case (state_q)
            ACC0:    cap_d = rd_m >> {off_q, 3'b000};
            ACC1:    cap_d = cap_q | (rd_m << up_sh);
            default: cap_d = cap_q;
        endcase
    end

    function automatic logic [31:0] ext(input logic [2:0] f3,
                                        input logic [31:0] v);
        case (f3)
            3'd0:    ext = {{24{v[7]}}, v[7:0]};
            3'd1:    ext = {{16{v[15]}}, v[15:0]};
            3'd4:    ext = {24'd0, v[7:0]};
            3'd5:    ext = {16'd0, v[15:0]};
            default: ext = v;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            a_q         <= '0;
            hi_mask_q   <= 4'd0;
            hi_wdata_q  <= 32'd0;
            cap_q       <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_mask_q  <= 4'd0;
            mem_wren_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q    <= 1'b0;
                        we_q       <= bus.i_req_we;
                        f3_q       <= bus.i_req_funct3;
                        off_q      <= off;
                        split_q    <= split;
                        a_q        <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
                        hi_mask_q  <= lanes[7:4];
                        hi_wdata_q <= wsh[63:32];
                        cap_q      <= 32'd0;
                        if (req_err) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q     <= ACC0;
                            mem_addr_q  <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
                            mem_mask_q  <= lanes[3:0];
                            mem_wdata_q <= wsh[31:0];
                            mem_wren_q  <= bus.i_req_we;
                        end
                    end
                end
                ACC0, ACC1: begin
                    cap_q <= cap_d;
                    if (state_q == ACC0 && split_q) begin
                        state_q     <= ACC1;
                        mem_addr_q  <= a_q + ADDR_W'(4);
                        mem_mask_q  <= hi_mask_q;
                        mem_wdata_q <= hi_wdata_q;
                        mem_wren_q  <= we_q;
                    end else begin
                        state_q     <= DONE;
                        mem_addr_q  <= '0;
                        mem_mask_q  <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        mem_wren_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'd0 : ext(f3_q, cap_d);
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
            endcase
        end
    end

    // Reset gates the outputs in its own cycle so a pending ACC1 write
    // cannot land on the edge that aborts the operation.
    assign bus.o_req_ready = ready_q & ~i_reset;
    assign bus.o_rsp_valid = rsp_valid_q & ~i_reset;
    assign bus.o_rsp_err   = rsp_err_q & ~i_reset;
    assign bus.o_rsp_rdata = i_reset ? 32'd0 : rsp_rdata_q;
    assign bus.o_mem_addr  = i_reset ? '0 : mem_addr_q;
    assign bus.o_mem_wdata = i_reset ? 32'd0 : mem_wdata_q;
    assign bus.o_mem_mask  = i_reset ? 4'd0 : mem_mask_q;
    assign bus.o_mem_wren  = mem_wren_q & ~i_reset;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed scoreboard bench for lsu_mem_master: two instances
// (split enabled / disabled) sharing one request stream.
module tb_lsu_mem_master;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_master_if #(.ADDR_W(AW)) b1 ();
    lsu_mem_master_if #(.ADDR_W(AW)) b0 ();

    lsu_mem_master #(.ADDR_W(AW), .SPLIT_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .bus(b1)
    );
    lsu_mem_master #(.ADDR_W(AW), .SPLIT_EN(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(b0)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (b1.o_mem_wren)
            for (int k = 0; k < 4; k++)
                if (b1.o_mem_mask[k])
                    mem[b1.o_mem_addr + AW'(k)] <= b1.o_mem_wdata[8*k +: 8];
    end

    always_comb begin
        b1.i_mem_rdata = 32'd0;
        for (int k = 0; k < 4; k++)
            if (b1.o_mem_mask[k])
                b1.i_mem_rdata[8*k +: 8] = mem[b1.o_mem_addr + AW'(k)];
    end

    assign b0.i_mem_rdata = 32'd0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   wdata;
        logic          wren;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    beat_t bq[$];
    rsp_t  rq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic w);
        bq.push_back('{a, m, d, w});
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        b1.i_req_we = we;  b0.i_req_we = we;
        b1.i_req_funct3 = f3;  b0.i_req_funct3 = f3;
        b1.i_req_addr = a;  b0.i_req_addr = a;
        b1.i_req_wdata = d;  b0.i_req_wdata = d;
    endtask

    task automatic req(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic err, input logic [31:0] rd,
                       input int lat);
        int            t0;
        bit            acc;
        bit            got;
        beat_t         eb;
        rsp_t          er;
        logic [AW-1:0] ma;
        logic [3:0]    mm;
        logic [31:0]   md;
        logic          mw;
        logic          rv;
        rq.push_back('{err, rd, lat});
        t0 = 0;
        acc = 1'b0;
        got = 1'b0;
        @(negedge clk);
        drive(we, f3, a, d);
        if (sel) b1.i_req_valid = 1'b1;
        else     b0.i_req_valid = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            if (sel ? b1.o_req_ready : b0.o_req_ready) begin
                acc = 1'b1;
                t0 = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("accept", 32'(acc), 32'd1);
        @(negedge clk);
        b1.i_req_valid = 1'b0;
        b0.i_req_valid = 1'b0;
        for (int i = 0; i < 8 && !got && acc; i++) begin
            ma = sel ? b1.o_mem_addr  : b0.o_mem_addr;
            mm = sel ? b1.o_mem_mask  : b0.o_mem_mask;
            md = sel ? b1.o_mem_wdata : b0.o_mem_wdata;
            mw = sel ? b1.o_mem_wren  : b0.o_mem_wren;
            rv = sel ? b1.o_rsp_valid : b0.o_rsp_valid;
            if (mm != 4'd0 || mw) begin
                if (bq.size() == 0) begin
                    chk("spurious_beat", {27'd0, mw, mm}, 32'd0);
                end else begin
                    eb = bq.pop_front();
                    chk("mem_addr", 32'(ma), 32'(eb.addr));
                    chk("mem_mask", 32'(mm), 32'(eb.mask));
                    chk("mem_wdata", md, eb.wdata);
                    chk("mem_wren", 32'(mw), 32'(eb.wren));
                end
            end
            if (rv) begin
                er = rq.pop_front();
                got = 1'b1;
                chk("rsp_lat", 32'(cyc - t0), 32'(er.lat));
                chk("rsp_err", 32'(sel ? b1.o_rsp_err : b0.o_rsp_err),
                    32'(er.err));
                chk("rsp_rdata", sel ? b1.o_rsp_rdata : b0.o_rsp_rdata,
                    er.rdata);
            end
            if (!got) @(negedge clk);
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("beats_left", 32'(bq.size()), 32'd0);
        bq.delete();
        rq.delete();
    endtask

    int nb;
    int nr;

    initial begin
        rst = 1'b1;
        b1.i_req_valid = 1'b0;
        b0.i_req_valid = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(b1.o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(b1.o_rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(b1.o_rsp_err), 32'd0);
        chk("rst_rsp_rdata", b1.o_rsp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(b1.o_mem_addr), 32'd0);
        chk("rst_mem_wdata", b1.o_mem_wdata, 32'd0);
        chk("rst_mem_mask", 32'(b1.o_mem_mask), 32'd0);
        chk("rst_mem_wren", 32'(b1.o_mem_wren), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready0", 32'(b1.o_req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready1", 32'(b1.o_req_ready), 32'd1);

        // T1 full-word store
        beat(16'h0100, 4'b1111, 32'hDEADBEEF, 1'b1);
        req(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0, 2);
        // T2 byte store then signed / unsigned byte loads
        beat(16'h0100, 4'b1000, 32'h80000000, 1'b1);
        req(1'b1, 1'b1, 3'd0, 32'h103, 32'h00000080, 1'b0, 32'd0, 2);
        beat(16'h0100, 4'b1000, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1'b0, 32'hFFFFFF80, 2);
        beat(16'h0100, 4'b1000, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 1'b0, 32'h00000080, 2);
        // illegal store must not touch memory
        req(1'b1, 1'b1, 3'd7, 32'h100, 32'h55555555, 1'b1, 32'd0, 1);
        beat(16'h0100, 4'b1111, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1'b0, 32'h80ADBEEF, 2);
        // T3 split store and load
        beat(16'h00FC, 4'b1100, 32'h33440000, 1'b1);
        beat(16'h0100, 4'b0011, 32'h00001122, 1'b1);
        req(1'b1, 1'b1, 3'd2, 32'h0FE, 32'h11223344, 1'b0, 32'd0, 3);
        beat(16'h00FC, 4'b1100, 32'd0, 1'b0);
        beat(16'h0100, 4'b0011, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd2, 32'h0FE, 32'd0, 1'b0, 32'h11223344, 3);
        // halfword sign / zero extension
        beat(16'h0200, 4'b0011, 32'h00008001, 1'b1);
        req(1'b1, 1'b1, 3'd1, 32'h200, 32'h00008001, 1'b0, 32'd0, 2);
        beat(16'h0200, 4'b0011, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd1, 32'h200, 32'd0, 1'b0, 32'hFFFF8001, 2);
        beat(16'h0200, 4'b0011, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd5, 32'h200, 32'd0, 1'b0, 32'h00008001, 2);
        // T4 address wrap on the second access
        beat(16'hFFFC, 4'b1000, 32'h34000000, 1'b1);
        req(1'b1, 1'b1, 3'd0, 32'hFFFF, 32'h00000034, 1'b0, 32'd0, 2);
        beat(16'h0000, 4'b0001, 32'h00000012, 1'b1);
        req(1'b1, 1'b1, 3'd0, 32'h0000, 32'h00000012, 1'b0, 32'd0, 2);
        beat(16'hFFFC, 4'b1000, 32'd0, 1'b0);
        beat(16'h0000, 4'b0001, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd1, 32'hFFFF, 32'd0, 1'b0, 32'h00001234, 3);
        // T5 errors
        req(1'b1, 1'b0, 3'd2, 32'h00010000, 32'd0, 1'b1, 32'd0, 1);
        req(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 1'b1, 32'd0, 1);
        req(1'b0, 1'b0, 3'd2, 32'h101, 32'd0, 1'b1, 32'd0, 1);
        beat(16'h0100, 4'b1100, 32'd0, 1'b0);
        req(1'b0, 1'b0, 3'd1, 32'h102, 32'd0, 1'b0, 32'd0, 2);

        // T6 reset during ACC1 of a split store
        beat(16'h00FC, 4'b1111, 32'hAAAAAAAA, 1'b1);
        req(1'b1, 1'b1, 3'd2, 32'h0FC, 32'hAAAAAAAA, 1'b0, 32'd0, 2);
        beat(16'h0100, 4'b1111, 32'hAAAAAAAA, 1'b1);
        req(1'b1, 1'b1, 3'd2, 32'h100, 32'hAAAAAAAA, 1'b0, 32'd0, 2);
        @(negedge clk);
        drive(1'b1, 3'd2, 32'h0FE, 32'h11223344);
        b1.i_req_valid = 1'b1;
        chk("t6_ready", 32'(b1.o_req_ready), 32'd1);
        @(negedge clk);
        b1.i_req_valid = 1'b0;
        chk("t6_acc0_mask", 32'(b1.o_mem_mask), 32'hC);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_wren", 32'(b1.o_mem_wren), 32'd0);
        chk("t6_rst_rsp", 32'(b1.o_rsp_valid), 32'd0);
        @(negedge clk);
        chk("t6_rst_ready", 32'(b1.o_req_ready), 32'd0);
        chk("t6_rst_rsp2", 32'(b1.o_rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_rel_ready0", 32'(b1.o_req_ready), 32'd0);
        @(negedge clk);
        chk("t6_rel_ready1", 32'(b1.o_req_ready), 32'd1);
        chk("t6_rel_rsp", 32'(b1.o_rsp_valid), 32'd0);
        chk("t6_mem_0fe", 32'(mem[16'h00FE]), 32'h44);
        chk("t6_mem_0ff", 32'(mem[16'h00FF]), 32'h33);
        chk("t6_mem_100", 32'(mem[16'h0100]), 32'hAA);
        chk("t6_mem_101", 32'(mem[16'h0101]), 32'hAA);
        beat(16'h00FC, 4'b1111, 32'd0, 1'b0);
        req(1'b1, 1'b0, 3'd2, 32'h0FC, 32'd0, 1'b0, 32'h3344AAAA, 2);

        // valid held while busy: exactly one access and one response
        nb = 0;
        nr = 0;
        @(negedge clk);
        drive(1'b0, 3'd2, 32'h100, 32'd0);
        b1.i_req_valid = 1'b1;
        chk("hold_ready", 32'(b1.o_req_ready), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) b1.i_req_valid = 1'b0;
            if (b1.o_mem_mask != 4'd0) nb++;
            if (b1.o_rsp_valid) nr++;
        end
        chk("hold_beats", 32'(nb), 32'd1);
        chk("hold_rsps", 32'(nr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
